pst_attn_seqn_core: RTL and testbench
=====================================

Name: pst_attn_seqn_core

Overview:
Parametrised successor of the closed-loop attention/sequence core. It scans all channel pairs sequentially, one pair per clock, and selects the most coincident pair (attention winner). It then learns the winner's position in a K-slot phase memory, with step size modulated by reward. A working-memory transition table predicts the next slot and drives top-down force injection. It sits between the phase_neuron layer (upstream) and predictive_phase (downstream).

Parameters:
N_CH, 4, number of phase channels (≥2); P = N_CH*(N_CH-1)/2 pairs
K_SLOTS, 4, sequence-memory slots (power of 2, ≥2)
ETA, 8, base slot learning step (phase units)
CONF_MIN, 2, minimum transition count for force_valid (1..3)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cycle_start  in  1  gamma-cycle boundary pulse; triggers snapshot and scan
phase_in  in  8*N_CH  channel phases, ch i at [8i+7:8i]
fired_in  in  N_CH  channel fired-this-cycle flags
reward_valid  in  1  reward strobe
reward_sign  in  1  1=punish, 0=reward
winner_pair  out  clog2(P)  winning pair index
winner_rel  out  8  winner relevance
winner_valid  out  1  1-clock result pulse
slot_idx  out  clog2(K_SLOTS)  matched slot
slot_val  out  8  matched slot value after update
force_pred  out  8  predicted next phase
force_valid  out  1  level; prediction confident
pred_err  out  8  circular |previous force_pred − current mapped value|
pred_err_valid  out  1  1-clock pulse with winner_valid
busy  out  1  scan in progress
overrun  out  1  sticky; cycle_start arrived while busy

Behaviour:
- Reset (sync, high): all outputs 0. Slot i = i*256/K_SLOTS. Transition counters 0. prev_valid=0. Reward latch = neutral. FSM = IDLE. Reset mid-scan aborts with no partial update.
- FSM is IDLE→SNAP→SCAN→UPDATE→IDLE. In IDLE, cycle_start registers phase_in/fired_in into a snapshot; busy=1 from the next clock.
- SCAN: one pair per clock, order (0,1),(0,2)…(0,N−1),(1,2)…, counter 0..P−1.
  - d = circular distance between the two phases, d = min(|a−b|, 256−|a−b|).
  - rel = max(0, 255−2d) if both fired, else 0.
  - A strictly greater rel replaces the best; ties keep the lower index.
- UPDATE: one clock after the last pair. winner_valid pulses on the following clock.
  - Latency: cycle_start at edge E0 gives winner_valid high after edge E(P+2); busy low at the same time.
- cycle_start while busy: ignored; overrun set until reset.
- Null cycle (best rel = 0): winner_valid pulses with winner_rel=0; winner_pair, slots, transitions and prev unchanged; force_valid=0; pred_err_valid=0.
- Mapping: m = floor(winner_pair*256/P). For N_CH=4: 0, 42, 85, 128, 170, 213. Implement as a constant table, no divider.
- Slot match: nearest slot by circular distance to m; ties go to the lowest index.
- Slot update: slot ← slot ± min(dist, eta_eff), moving toward m on the short arc, mod 256.
- eta_eff:
  - ETA*2, saturated to 255, if the latched reward is positive;
  - ETA>>1 if negative;
  - ETA if none.
  - The reward latch captures on reward_valid at any time and clears on consumption in UPDATE. A strobe coinciding with UPDATE applies to the next update.
- Transitions: 2-bit saturating counters T[prev][cur].
  - If prev_valid: T[prev][cur]++ (saturates at 3); other entries in row prev decrement (saturate at 0).
  - Then prev ← cur, prev_valid ← 1.
- Prediction: next = argmax T[cur][*], ties lowest index.
  - force_valid = (T[cur][next] ≥ CONF_MIN).
  - force_pred = slot[next] using post-update slot values.
  - Both are held until the next non-null UPDATE.
- pred_err: computed only if force_valid was 1 before this UPDATE; pred_err_valid pulses with winner_valid.

Test Plan:
- Reset, then idle 10 clocks → all outputs 0; rst asserted mid-SCAN → busy=0, slots back to 0/64/128/192.
- N_CH=4, phases 50/52/200/120, all fired, cycle_start → winner_valid after E8, winner_pair=0, winner_rel=251, slot_idx=0, slot_val=0.
- Phases 10/180/100/100 (CD) from reset → winner_pair=5, winner_rel=255, m=213, slot_idx=3, slot_val=200; repeat with reward+ → 208; with reward− → 196.
- Sequence AB, CD, AB, CD, AB (one per 256-clock cycle):
  - force_valid first rises after the 5th event, with force_pred=208.
  - On a 6th CD event, pred_err=|208−213|=5 with pred_err_valid=1.
- Only channel 0 fired → winner_rel=0, winner_valid pulses, slots and force outputs unchanged; equal rel on pairs 1 and 3 → winner_pair=1.
- cycle_start pulses 3 clocks apart → second ignored, overrun=1 sticky until rst.

Source files
------------

// File: rtl/pst_attn_seqn_if.sv
// Handshake/result bundle between the phase_neuron layer, the attention/sequence core and predictive_phase.
interface pst_attn_seqn_if #(
  parameter int N_CH    = 4,
  parameter int K_SLOTS = 4
);
  localparam int P  = N_CH * (N_CH - 1) / 2;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int SW = $clog2(K_SLOTS);

  logic                cycle_start;
  logic [8*N_CH-1:0]   phase_in;
  logic [N_CH-1:0]     fired_in;
  logic                reward_valid;
  logic                reward_sign;
  logic [PW-1:0]       winner_pair;
  logic [7:0]          winner_rel;
  logic                winner_valid;
  logic [SW-1:0]       slot_idx;
  logic [7:0]          slot_val;
  logic [7:0]          force_pred;
  logic                force_valid;
  logic [7:0]          pred_err;
  logic                pred_err_valid;
  logic                busy;
  logic                overrun;

  modport master (
    output cycle_start, phase_in, fired_in, reward_valid, reward_sign,
    input  winner_pair, winner_rel, winner_valid, slot_idx, slot_val,
           force_pred, force_valid, pred_err, pred_err_valid, busy, overrun
  );

  modport slave (
    input  cycle_start, phase_in, fired_in, reward_valid, reward_sign,
    output winner_pair, winner_rel, winner_valid, slot_idx, slot_val,
           force_pred, force_valid, pred_err, pred_err_valid, busy, overrun
  );
endinterface

// File: rtl/pst_attn_seqn_core.sv
// Attention/sequence core: sequential pair scan for the most coincident channel pair,
// reward-modulated slot learning and a saturating transition table driving force prediction.
module pst_attn_seqn_core #(
  parameter int N_CH     = 4,
  parameter int K_SLOTS  = 4,
  parameter int ETA      = 8,
  parameter int CONF_MIN = 2
) (
  input  logic           clk,
  input  logic           rst,
  pst_attn_seqn_if.slave bus
);
  localparam int P  = N_CH * (N_CH - 1) / 2;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int SW = $clog2(K_SLOTS);
  localparam int CW = $clog2(N_CH);

  typedef enum logic [1:0] {IDLE, SNAP, SCAN, UPDATE} state_t;

  function automatic logic [7:0] circ_dist(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] diff;
    diff = a - b;
    return diff[7] ? 8'(8'd0 - diff) : diff;
  endfunction

  function automatic logic [7:0] rel_sat(input logic [7:0] d);
    logic signed [9:0] r;
    r = 10'sd255 - $signed({1'b0, d, 1'b0});
    return (r < 0) ? 8'd0 : r[7:0];
  endfunction

  function automatic logic [7:0] eta_sat(input logic pend, input logic neg);
    int e;
    if (!pend)    e = ETA;
    else if (neg) e = ETA >> 1;
    else          e = (ETA * 2 > 255) ? 255 : ETA * 2;
    return 8'(e);
  endfunction

  function automatic logic [1:0] cnt_inc(input logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] cnt_dec(input logic [1:0] c);
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  state_t state_q, state_d;

  logic [8*N_CH-1:0] snap_phase_p0;
  logic [N_CH-1:0]   snap_fired_p0;
  logic [CW-1:0]     ch_a, ch_b;
  logic [PW-1:0]     pair_cnt;
  logic [7:0]        scan_rel;
  logic [7:0]        best_rel_p1;
  logic [PW-1:0]     best_idx_p1;

  logic [K_SLOTS-1:0][7:0]               slot_q, slot_d;
  logic [K_SLOTS-1:0][K_SLOTS-1:0][1:0]  trans_q, trans_d;
  logic [SW-1:0] prev_q;
  logic          prev_valid_q;
  logic          rew_pend_q, rew_neg_q;

  logic [7:0]    map_tab [2**PW];
  logic [7:0]    m_val, hit_d, step, dir, new_slot, eta_eff, pe_nxt, fp_nxt;
  logic [SW-1:0] slot_hit, pred_nxt;
  logic [1:0]    pred_cnt;
  logic          fv_nxt;

  logic [PW-1:0] winner_pair_q;
  logic [7:0]    winner_rel_q, slot_val_q, force_pred_q, pred_err_q;
  logic [SW-1:0] slot_idx_q;
  logic          winner_valid_q, force_valid_q, pred_err_valid_q, overrun_q;

  // Pair index -> phase position, folded to constants at elaboration.
  for (genvar g = 0; g < 2**PW; g++) begin : g_map
    assign map_tab[g] = (g < P) ? 8'((g * 256) / P) : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cycle_start) state_d = SNAP;
      SNAP:    state_d = SCAN;
      SCAN:    if (pair_cnt == PW'(P - 1)) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: snapshot; stage p1: running best over the pair scan.
  always_comb begin
    scan_rel = '0;
    if (snap_fired_p0[ch_a] && snap_fired_p0[ch_b])
      scan_rel = rel_sat(circ_dist(snap_phase_p0[8*ch_a +: 8], snap_phase_p0[8*ch_b +: 8]));
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.cycle_start) begin
      snap_phase_p0 <= bus.phase_in;
      snap_fired_p0 <= bus.fired_in;
    end
    if (state_q == SNAP) begin
      best_rel_p1 <= '0;
      best_idx_p1 <= '0;
    end else if (state_q == SCAN && scan_rel > best_rel_p1) begin
      best_rel_p1 <= scan_rel;
      best_idx_p1 <= pair_cnt;
    end
  end

  // Update stage: slot match/learn, transition table and next-slot prediction.
  always_comb begin
    eta_eff  = eta_sat(rew_pend_q, rew_neg_q);
    m_val    = map_tab[best_idx_p1];
    slot_hit = '0;
    hit_d    = circ_dist(slot_q[0], m_val);
    for (int k = 1; k < K_SLOTS; k++) begin
      if (circ_dist(slot_q[k], m_val) < hit_d) begin
        slot_hit = SW'(k);
        hit_d    = circ_dist(slot_q[k], m_val);
      end
    end
    step     = (hit_d < eta_eff) ? hit_d : eta_eff;
    dir      = m_val - slot_q[slot_hit];
    new_slot = dir[7] ? slot_q[slot_hit] - step : slot_q[slot_hit] + step;
    slot_d   = slot_q;
    slot_d[slot_hit] = new_slot;

    trans_d = trans_q;
    if (prev_valid_q)
      for (int j = 0; j < K_SLOTS; j++)
        trans_d[prev_q][j] = (SW'(j) == slot_hit) ? cnt_inc(trans_q[prev_q][j])
                                                  : cnt_dec(trans_q[prev_q][j]);
    pred_nxt = '0;
    pred_cnt = trans_d[slot_hit][0];
    for (int k = 1; k < K_SLOTS; k++) begin
      if (trans_d[slot_hit][k] > pred_cnt) begin
        pred_nxt = SW'(k);
        pred_cnt = trans_d[slot_hit][k];
      end
    end
    fv_nxt = (pred_cnt >= 2'(CONF_MIN));
    fp_nxt = slot_d[pred_nxt];
    pe_nxt = circ_dist(force_pred_q, m_val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_a             <= '0;
      ch_b             <= '0;
      pair_cnt         <= '0;
      for (int k = 0; k < K_SLOTS; k++) slot_q[k] <= 8'(k * (256 / K_SLOTS));
      trans_q          <= '0;
      prev_q           <= '0;
      prev_valid_q     <= 1'b0;
      rew_pend_q       <= 1'b0;
      rew_neg_q        <= 1'b0;
      winner_pair_q    <= '0;
      winner_rel_q     <= '0;
      winner_valid_q   <= 1'b0;
      slot_idx_q       <= '0;
      slot_val_q       <= '0;
      force_pred_q     <= '0;
      force_valid_q    <= 1'b0;
      pred_err_q       <= '0;
      pred_err_valid_q <= 1'b0;
      overrun_q        <= 1'b0;
    end else begin
      winner_valid_q   <= 1'b0;
      pred_err_valid_q <= 1'b0;
      if (bus.reward_valid) begin
        rew_pend_q <= 1'b1;
        rew_neg_q  <= bus.reward_sign;
      end
      if (bus.cycle_start && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        SNAP: begin
          pair_cnt <= '0;
          ch_a     <= '0;
          ch_b     <= CW'(1);
        end
        SCAN: begin
          pair_cnt <= pair_cnt + PW'(1);
          if (ch_b == CW'(N_CH - 1)) begin
            ch_a <= ch_a + CW'(1);
            ch_b <= ch_a + CW'(2);
          end else begin
            ch_b <= ch_b + CW'(1);
          end
        end
        UPDATE: begin
          winner_valid_q <= 1'b1;
          winner_rel_q   <= best_rel_p1;
          if (best_rel_p1 != 8'd0) begin
            winner_pair_q    <= best_idx_p1;
            slot_idx_q       <= slot_hit;
            slot_val_q       <= new_slot;
            slot_q           <= slot_d;
            trans_q          <= trans_d;
            prev_q           <= slot_hit;
            prev_valid_q     <= 1'b1;
            force_pred_q     <= fp_nxt;
            force_valid_q    <= fv_nxt;
            pred_err_valid_q <= force_valid_q;
            if (force_valid_q) pred_err_q <= pe_nxt;
            // A strobe landing on this edge stays latched for the next update.
            if (!bus.reward_valid) rew_pend_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.winner_pair    = winner_pair_q;
  assign bus.winner_rel     = winner_rel_q;
  assign bus.winner_valid   = winner_valid_q;
  assign bus.slot_idx       = slot_idx_q;
  assign bus.slot_val       = slot_val_q;
  assign bus.force_pred     = force_pred_q;
  assign bus.force_valid    = force_valid_q;
  assign bus.pred_err       = pred_err_q;
  assign bus.pred_err_valid = pred_err_valid_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.overrun        = overrun_q;
endmodule

// File: tb/tb_pst_attn_seqn_core.sv
// Directed bench for pst_attn_seqn_core (N_CH=4, K_SLOTS=4, ETA=8, CONF_MIN=2).
module tb_pst_attn_seqn_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pst_attn_seqn_if #(.N_CH(4), .K_SLOTS(4)) bus ();
  pst_attn_seqn_core #(.N_CH(4), .K_SLOTS(4), .ETA(8), .CONF_MIN(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  localparam logic [31:0] PH_AB  = {8'd120, 8'd200, 8'd52, 8'd50};
  localparam logic [31:0] PH_CD  = {8'd100, 8'd100, 8'd180, 8'd10};
  localparam logic [31:0] PH_TIE = {8'd230, 8'd100, 8'd110, 8'd90};

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          do_rst;
    logic [31:0] ph;
    logic [3:0]  fr;
    int          rw;      // 0 none, 1 reward, 2 punish
    int          e_pair, e_rel, e_sidx, e_sval, e_fv, e_pev;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Starts one gamma cycle and waits (bounded) for the result pulse.
  task automatic run_cycle(input string tag, input logic [31:0] ph, input logic [3:0] fr,
                           input int rw);
    int lat;
    bus.phase_in = ph;
    bus.fired_in = fr;
    if (rw != 0) begin
      bus.reward_valid = 1'b1;
      bus.reward_sign  = (rw == 2);
      tick();
      bus.reward_valid = 1'b0;
      bus.reward_sign  = 1'b0;
    end
    bus.cycle_start = 1'b1;
    tick();
    bus.cycle_start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.winner_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_busy_at_result"}, int'(bus.busy), 0);
  endtask

  task automatic check_outputs(input string tag, input int e_pair, input int e_rel,
                               input int e_sidx, input int e_sval, input int e_fv,
                               input int e_pev);
    chk({tag, "_winner_pair"}, int'(bus.winner_pair), e_pair);
    chk({tag, "_winner_rel"}, int'(bus.winner_rel), e_rel);
    chk({tag, "_slot_idx"}, int'(bus.slot_idx), e_sidx);
    chk({tag, "_slot_val"}, int'(bus.slot_val), e_sval);
    chk({tag, "_force_valid"}, int'(bus.force_valid), e_fv);
    chk({tag, "_pred_err_valid"}, int'(bus.pred_err_valid), e_pev);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    logic [31:0] ph_seq;
    int exp_fv  [6] = '{0, 0, 0, 0, 1, 1};
    int exp_pev [6] = '{0, 0, 0, 0, 0, 1};
    int exp_sidx[6] = '{0, 3, 0, 3, 0, 3};
    int exp_sval[6] = '{0, 200, 0, 208, 0, 213};

    vecs[0] = '{1'b1, PH_AB,  4'hF, 0, 0, 251, 0, 0,   0, 0};
    vecs[1] = '{1'b1, PH_CD,  4'hF, 0, 5, 255, 3, 200, 0, 0};
    vecs[2] = '{1'b1, PH_CD,  4'hF, 1, 5, 255, 3, 208, 0, 0};
    vecs[3] = '{1'b1, PH_CD,  4'hF, 2, 5, 255, 3, 196, 0, 0};
    vecs[4] = '{1'b1, PH_AB,  4'h1, 0, 0, 0,   0, 0,   0, 0};
    vecs[5] = '{1'b1, PH_TIE, 4'hF, 0, 1, 235, 1, 56,  0, 0};
    vecs[6] = '{1'b0, PH_AB,  4'h1, 0, 1, 0,   1, 56,  0, 0};

    bus.cycle_start  = 1'b0;
    bus.phase_in     = '0;
    bus.fired_in     = '0;
    bus.reward_valid = 1'b0;
    bus.reward_sign  = 1'b0;

    // Reset state after 10 idle clocks.
    do_reset();
    repeat (10) tick();
    chk("rst_winner_pair", int'(bus.winner_pair), 0);
    chk("rst_winner_rel", int'(bus.winner_rel), 0);
    chk("rst_winner_valid", int'(bus.winner_valid), 0);
    chk("rst_slot_idx", int'(bus.slot_idx), 0);
    chk("rst_slot_val", int'(bus.slot_val), 0);
    chk("rst_force_pred", int'(bus.force_pred), 0);
    chk("rst_force_valid", int'(bus.force_valid), 0);
    chk("rst_pred_err", int'(bus.pred_err), 0);
    chk("rst_pred_err_valid", int'(bus.pred_err_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_overrun", int'(bus.overrun), 0);

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 7; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (vecs[i].do_rst) do_reset();
      run_cycle(tag, vecs[i].ph, vecs[i].fr, vecs[i].rw);
      check_outputs(tag, vecs[i].e_pair, vecs[i].e_rel, vecs[i].e_sidx, vecs[i].e_sval,
                    vecs[i].e_fv, vecs[i].e_pev);
      tick();
      chk({tag, "_wv_pulse_end"}, int'(bus.winner_valid), 0);
      repeat (3) tick();
    end

    // Sequence AB,CD,AB,CD,AB,CD, one event per 256-clock cycle.
    do_reset();
    for (int e = 0; e < 6; e++) begin
      string tag;
      tag = $sformatf("seq%0d", e);
      ph_seq = (e % 2 == 0) ? PH_AB : PH_CD;
      run_cycle(tag, ph_seq, 4'hF, 0);
      chk({tag, "_force_valid"}, int'(bus.force_valid), exp_fv[e]);
      chk({tag, "_pred_err_valid"}, int'(bus.pred_err_valid), exp_pev[e]);
      chk({tag, "_slot_idx"}, int'(bus.slot_idx), exp_sidx[e]);
      chk({tag, "_slot_val"}, int'(bus.slot_val), exp_sval[e]);
      if (e == 4) chk("seq4_force_pred", int'(bus.force_pred), 208);
      if (e == 5) begin
        chk("seq5_pred_err", int'(bus.pred_err), 5);
        chk("seq5_force_pred", int'(bus.force_pred), 0);
      end
      repeat (256 - 11) tick();
    end

    // Reset mid-scan aborts; a pending reward is dropped and slots return to defaults.
    bus.reward_valid = 1'b1;
    bus.reward_sign  = 1'b0;
    tick();
    bus.reward_valid = 1'b0;
    bus.phase_in     = PH_CD;
    bus.fired_in     = 4'hF;
    bus.cycle_start  = 1'b1;
    tick();
    bus.cycle_start  = 1'b0;
    repeat (4) tick();
    chk("abort_busy_before", int'(bus.busy), 1);
    rst = 1'b1;
    tick();
    chk("abort_busy_in_rst", int'(bus.busy), 0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.winner_valid) seen = 1;
    end
    chk("abort_no_result", seen, 0);
    run_cycle("post_abort", PH_CD, 4'hF, 0);
    chk("post_abort_slot_idx", int'(bus.slot_idx), 3);
    chk("post_abort_slot_val", int'(bus.slot_val), 200);
    chk("post_abort_force_valid", int'(bus.force_valid), 0);

    // cycle_start 3 clocks apart: second is ignored, overrun sticks until reset.
    do_reset();
    bus.phase_in    = PH_AB;
    bus.fired_in    = 4'hF;
    bus.cycle_start = 1'b1;
    tick();
    bus.cycle_start = 1'b0;
    tick();
    tick();
    chk("ovr_before", int'(bus.overrun), 0);
    bus.cycle_start = 1'b1;
    tick();
    bus.cycle_start = 1'b0;
    chk("ovr_set", int'(bus.overrun), 1);
    seen = -1;
    for (int k = 4; k <= 40; k++) begin
      tick();
      if (bus.winner_valid) begin
        seen = k;
        break;
      end
    end
    chk("ovr_latency", seen, 8);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.winner_valid || bus.busy) seen = 1;
    end
    chk("ovr_second_ignored", seen, 0);
    run_cycle("ovr_next", PH_CD, 4'hF, 0);
    chk("ovr_sticky", int'(bus.overrun), 1);
    do_reset();
    chk("ovr_cleared", int'(bus.overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
